// File: rtl/maze_path_engine.sv
// maze_path_engine: depth-first maze solver from (0,0) to (N-1,N-1) over an external
// 1-bit maze memory, keeping the move path on an internal stack for later replay.
module maze_path_engine #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned PTR_W   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               replay,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [COORD_W-1:0] mem_x,
  output logic [COORD_W-1:0] mem_y,
  output logic               mem_wdata,
  input  logic               mem_din,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic [PTR_W-1:0]   depth,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic               overflow,
  output logic               path_valid,
  input  logic               path_ready,
  output logic [1:0]         path_dir,
  output logic               path_last
);
  localparam int unsigned        AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]   FULL  = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0]   P_ONE = PTR_W'(1);
  localparam logic [COORD_W-1:0] X_ONE = COORD_W'(1);
  localparam logic [COORD_W:0]   N_ONE = (COORD_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PROBE, S_EVAL, S_BACK, S_DONE, S_FAIL, S_REPLAY
  } state_t;

  state_t             state;
  logic [1:0]         dir;
  logic [PTR_W-1:0]   sp;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   sp_m1;
  logic [1:0]         stack [2**AW];
  logic [1:0]         top;
  logic [COORD_W:0]   nx, ny;
  logic [COORD_W-1:0] bx, by;
  logic               oor, full, idle_like, push, last;

  // Neighbour is computed one bit wider so a carry/borrow flags out-of-range.
  always_comb begin
    nx = {1'b0, cur_x};
    ny = {1'b0, cur_y};
    unique case (dir)
      2'd0: ny = {1'b0, cur_y} - N_ONE;
      2'd1: nx = {1'b0, cur_x} + N_ONE;
      2'd2: nx = {1'b0, cur_x} - N_ONE;
      2'd3: ny = {1'b0, cur_y} + N_ONE;
    endcase
  end

  assign sp_m1 = sp - P_ONE;
  assign top   = stack[sp_m1[AW-1:0]];

  // Undo the move that was popped.
  always_comb begin
    bx = cur_x;
    by = cur_y;
    unique case (top)
      2'd0: by = cur_y + X_ONE;
      2'd1: bx = cur_x - X_ONE;
      2'd2: bx = cur_x + X_ONE;
      2'd3: by = cur_y - X_ONE;
    endcase
  end

  assign oor       = nx[COORD_W] | ny[COORD_W];
  assign full      = (sp == FULL);
  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_FAIL);
  assign push      = !rst && (state == S_EVAL) && !mem_din && !full;
  assign last      = (rd_ptr == sp_m1);

  assign mem_rd     = !rst && (state == S_PROBE) && !oor;
  assign mem_wr     = !rst && ((idle_like && start) || push);
  assign mem_x      = idle_like ? '0 : nx[COORD_W-1:0];
  assign mem_y      = idle_like ? '0 : ny[COORD_W-1:0];
  assign mem_wdata  = 1'b1;
  assign depth      = sp;
  assign busy       = (state == S_CHECK) || (state == S_PROBE) ||
                      (state == S_EVAL)  || (state == S_BACK);
  assign done       = (state == S_DONE) || (state == S_REPLAY);
  assign fail       = (state == S_FAIL);
  assign path_valid = (state == S_REPLAY);
  assign path_dir   = (state == S_REPLAY) ? stack[rd_ptr[AW-1:0]] : 2'b00;
  assign path_last  = (state == S_REPLAY) && last;

  always_ff @(posedge clk) begin
    if (push) stack[sp[AW-1:0]] <= dir;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cur_x    <= '0;
      cur_y    <= '0;
      dir      <= '0;
      sp       <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            cur_x    <= '0;
            cur_y    <= '0;
            dir      <= '0;
            sp       <= '0;
            overflow <= 1'b0;
            state    <= S_CHECK;
          end else if (state == S_DONE && replay) begin
            rd_ptr <= '0;
            state  <= S_REPLAY;
          end
        end
        S_CHECK: state <= (&cur_x && &cur_y) ? S_DONE : S_PROBE;
        S_PROBE: begin
          if (!oor)              state <= S_EVAL;
          else if (dir == 2'd3)  state <= S_BACK;
          else                   dir   <= dir + 2'd1;
        end
        S_EVAL: begin
          if (mem_din) begin
            if (dir == 2'd3) state <= S_BACK;
            else begin
              dir   <= dir + 2'd1;
              state <= S_PROBE;
            end
          end else if (full) begin
            overflow <= 1'b1;
            state    <= S_FAIL;
          end else begin
            sp    <= sp + P_ONE;
            cur_x <= nx[COORD_W-1:0];
            cur_y <= ny[COORD_W-1:0];
            dir   <= '0;
            state <= S_CHECK;
          end
        end
        S_BACK: begin
          if (sp == '0) state <= S_FAIL;
          else begin
            sp    <= sp_m1;
            cur_x <= bx;
            cur_y <= by;
            if (top != 2'd3) begin
              dir   <= top + 2'd1;
              state <= S_PROBE;
            end
          end
        end
        S_REPLAY: begin
          if (path_ready) begin
            rd_ptr <= rd_ptr + P_ONE;
            if (last) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maze_path_engine.sv
// Bench for maze_path_engine: three configurations share one maze memory model; a
// behavioural DFS reference predicts path, status, cycle count and memory marks.
module tb_maze_path_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, replay = 1'b0, path_ready = 1'b0, load = 1'b0;
  int unsigned sel = 0;
  logic [2:0]  start_v, replay_v;
  assign start_v  = start  ? 3'(1 << sel) : 3'b000;
  assign replay_v = replay ? 3'(1 << sel) : 3'b000;

  logic mem [16];
  logic walls [16];
  logic din_q;
  int   wr_cnt;

  logic       a_rd, a_wr, a_wd, a_busy, a_done, a_fail, a_ovf, a_pv, a_pl;
  logic [1:0] a_mx, a_my, a_cx, a_cy, a_pd;
  logic [4:0] a_depth;
  logic       b_rd, b_wr, b_wd, b_busy, b_done, b_fail, b_ovf, b_pv, b_pl;
  logic [1:0] b_mx, b_my, b_cx, b_cy, b_pd;
  logic [1:0] b_depth;
  logic       c_rd, c_wr, c_wd, c_busy, c_done, c_fail, c_ovf, c_pv, c_pl;
  logic       c_mx, c_my, c_cx, c_cy;
  logic [1:0] c_pd;
  logic [2:0] c_depth;

  maze_path_engine #(.COORD_W(2), .DEPTH(16), .PTR_W(5)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .replay(replay_v[0]),
    .mem_rd(a_rd), .mem_wr(a_wr), .mem_x(a_mx), .mem_y(a_my), .mem_wdata(a_wd),
    .mem_din(din_q), .cur_x(a_cx), .cur_y(a_cy), .depth(a_depth), .busy(a_busy),
    .done(a_done), .fail(a_fail), .overflow(a_ovf), .path_valid(a_pv),
    .path_ready(path_ready), .path_dir(a_pd), .path_last(a_pl));

  maze_path_engine #(.COORD_W(2), .DEPTH(2), .PTR_W(2)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .replay(replay_v[1]),
    .mem_rd(b_rd), .mem_wr(b_wr), .mem_x(b_mx), .mem_y(b_my), .mem_wdata(b_wd),
    .mem_din(din_q), .cur_x(b_cx), .cur_y(b_cy), .depth(b_depth), .busy(b_busy),
    .done(b_done), .fail(b_fail), .overflow(b_ovf), .path_valid(b_pv),
    .path_ready(path_ready), .path_dir(b_pd), .path_last(b_pl));

  maze_path_engine #(.COORD_W(1), .DEPTH(4), .PTR_W(3)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .replay(replay_v[2]),
    .mem_rd(c_rd), .mem_wr(c_wr), .mem_x(c_mx), .mem_y(c_my), .mem_wdata(c_wd),
    .mem_din(din_q), .cur_x(c_cx), .cur_y(c_cy), .depth(c_depth), .busy(c_busy),
    .done(c_done), .fail(c_fail), .overflow(c_ovf), .path_valid(c_pv),
    .path_ready(path_ready), .path_dir(c_pd), .path_last(c_pl));

  logic [23:0] bus_a, bus_b, bus_c, bus_s;
  assign bus_a = {a_wd, a_busy, a_done, a_fail, a_ovf, a_rd, a_wr, a_pv, a_pl, a_pd,
                  a_depth, a_cx, a_cy, a_mx, a_my};
  assign bus_b = {b_wd, b_busy, b_done, b_fail, b_ovf, b_rd, b_wr, b_pv, b_pl, b_pd,
                  5'(b_depth), b_cx, b_cy, b_mx, b_my};
  assign bus_c = {c_wd, c_busy, c_done, c_fail, c_ovf, c_rd, c_wr, c_pv, c_pl, c_pd,
                  5'(c_depth), 2'(c_cx), 2'(c_cy), 2'(c_mx), 2'(c_my)};

  logic       o_wd, o_busy, o_done, o_fail, o_ovf, o_rd, o_wr, o_pv, o_pl;
  logic [1:0] o_pd, o_cx, o_cy, o_mx, o_my;
  logic [4:0] o_depth;
  always_comb begin
    case (sel)
      0:       bus_s = bus_a;
      1:       bus_s = bus_b;
      default: bus_s = bus_c;
    endcase
    {o_wd, o_busy, o_done, o_fail, o_ovf, o_rd, o_wr, o_pv, o_pl, o_pd,
     o_depth, o_cx, o_cy, o_mx, o_my} = bus_s;
  end

  // Maze memory: index = y*4 + x, one read/write port driven by the selected engine.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= walls[i];
      wr_cnt <= 0;
    end else begin
      if (o_wr) begin
        mem[{o_my, o_mx}] <= 1'b1;
        wr_cnt <= wr_cnt + 1;
      end
      if (o_rd) din_q <= mem[{o_my, o_mx}];
    end
  end

  int errors = 0, checks = 0;
  int m_status, m_ovf, m_cyc, m_wr, m_x, m_y, last_cyc;
  int exp_path[$];
  bit m_vis[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_walls(input logic [15:0] w);
    for (int i = 0; i < 16; i++) walls[i] = w[i];
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  // Reference: walk the DFS rules directly, counting 1 cycle per check/backtrack step,
  // 1 per out-of-range probe and 2 per in-range probe.
  task automatic model(input int n, input int limit);
    int phase, d, nx, ny, dx, dy;
    for (int i = 0; i < 16; i++) m_vis[i] = walls[i];
    m_vis[0] = 1'b1;
    m_wr = 1; m_cyc = 0; m_ovf = 0; m_status = 0; m_x = 0; m_y = 0;
    exp_path.delete();
    phase = 0; d = 0;
    while (m_status == 0) begin
      if (phase == 0) begin
        m_cyc++;
        if (m_x == n - 1 && m_y == n - 1) m_status = 1;
        else begin d = 0; phase = 1; end
      end else if (phase == 1) begin
        if (d == 4) phase = 2;
        else begin
          dx = (d == 1) ? 1 : (d == 2) ? -1 : 0;
          dy = (d == 3) ? 1 : (d == 0) ? -1 : 0;
          nx = m_x + dx; ny = m_y + dy;
          if (nx < 0 || ny < 0 || nx >= n || ny >= n) begin m_cyc++; d++; end
          else begin
            m_cyc += 2;
            if (m_vis[ny*4+nx]) d++;
            else if (exp_path.size() == limit) begin m_ovf = 1; m_status = 2; end
            else begin
              m_vis[ny*4+nx] = 1'b1; m_wr++; exp_path.push_back(d);
              m_x = nx; m_y = ny; phase = 0;
            end
          end
        end
      end else begin
        m_cyc++;
        if (exp_path.size() == 0) m_status = 2;
        else begin
          d = exp_path.pop_back();
          m_x -= (d == 1) ? 1 : (d == 2) ? -1 : 0;
          m_y -= (d == 3) ? 1 : (d == 0) ? -1 : 0;
          d++; phase = 1;
        end
      end
    end
  endtask

  task automatic run_search(input int unsigned s, input int n, input int limit, input string tag);
    int guard;
    logic [15:0] mv, vv;
    model(n, limit);
    sel = s;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    last_cyc = 0; guard = 0;
    while (!(o_done || o_fail) && guard < 1000) begin
      if (o_busy) last_cyc++;
      guard++;
      @(negedge clk);
    end
    chk({tag, " timeout"}, 32'(guard < 1000), 1);
    chk({tag, " cycles"}, last_cyc, m_cyc);
    chk({tag, " done"}, o_done, 32'(m_status == 1));
    chk({tag, " fail"}, o_fail, 32'(m_status == 2));
    chk({tag, " overflow"}, o_ovf, m_ovf);
    chk({tag, " depth"}, o_depth, exp_path.size());
    chk({tag, " cur"}, {o_cx, o_cy}, {2'(m_x), 2'(m_y)});
    chk({tag, " writes"}, wr_cnt, m_wr);
    for (int i = 0; i < 16; i++) begin mv[i] = mem[i]; vv[i] = m_vis[i]; end
    chk({tag, " marks"}, mv, vv);
  endtask

  task automatic run_replay(input string tag, input int stall);
    int k, guard;
    @(negedge clk) replay = 1'b1;
    @(negedge clk) replay = 1'b0;
    k = 0; guard = 0;
    while (o_pv && guard < 200) begin
      chk({tag, " dir"}, o_pd, exp_path[k]);
      chk({tag, " last"}, o_pl, 32'(k == exp_path.size() - 1));
      path_ready = (guard >= stall);
      @(negedge clk);
      if (path_ready) k++;
      guard++;
    end
    path_ready = 1'b0;
    chk({tag, " transfers"}, k, exp_path.size());
    chk({tag, " back in done"}, {o_done, o_pv}, 2'b10);
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    chk("reset flags", {o_busy, o_done, o_fail, o_ovf, o_pv, o_pl, o_rd, o_wr}, 8'h00);
    chk("reset depth", o_depth, 0);
    chk("reset cur", {o_cx, o_cy, o_mx, o_my, o_pd}, 10'h000);
    rst = 1'b0;

    // T1: reset in the middle of a search
    set_walls(16'h0000);
    sel = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    chk("T1 busy before reset", o_busy, 1);
    rst = 1'b1;
    @(negedge clk); @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("T1 flags", {o_busy, o_done, o_fail, o_rd, o_wr}, 5'b00000);
    chk("T1 depth", o_depth, 0);
    chk("T1 cur", {o_cx, o_cy}, 4'h0);
    chk("T1 wdata", o_wd, 1);

    // T2 / T6: 2x2 empty maze, plain replay then a stalled replay
    set_walls(16'h0000);
    run_search(2, 2, 4, "T2");
    chk("T2 spec cycles", last_cyc, 12);
    run_replay("T2 replay", 0);
    run_replay("T6 replay", 3);

    // T3: walls (3,1),(1,1), one backtrack
    set_walls(16'h00A0);
    run_search(0, 4, 16, "T3");
    chk("T3 spec depth", o_depth, 6);
    run_replay("T3 replay", 1);

    // T4: start boxed in -> no path; replay in FAIL is ignored
    set_walls(16'h0012);
    run_search(0, 4, 16, "T4");
    @(negedge clk) replay = 1'b1;
    @(negedge clk) replay = 1'b0;
    @(negedge clk);
    chk("T4 replay ignored", {o_fail, o_pv}, 2'b10);

    // T5: stack of two fills up
    set_walls(16'h0000);
    run_search(1, 4, 2, "T5");
    chk("T5 third cell untouched", mem[3], 1'b0);

    for (int it = 0; it < 24; it++) begin
      logic [15:0] w;
      int unsigned s;
      w = 16'($urandom) & 16'($urandom);
      s = $urandom_range(0, 1);
      set_walls(w);
      run_search(s, 4, (s == 0) ? 16 : 2, $sformatf("R%0d", it));
      if (o_done) run_replay($sformatf("R%0d replay", it), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
